// File: rtl/verif_pkg.sv
// rtl/verif_pkg.sv - shared run-control types, defaults and helpers
package verif_pkg;

    // Run sequencing states of the test-run controller
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } run_state_t;

    // Static run-control constants, used as parameter defaults
    localparam int MAX_LOOP_COUNT        = 3;
    localparam int STOP_AT_ERROR         = 0;
    localparam int HEART_BEAT            = 1;
    localparam int HEART_BEAT_CYCLES_DEF = 1000;
    localparam int TIMEOUT_CYCLES_DEF    = 10000;

    // Number of set bits in a channel vector (channels are at most 32 wide)
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/verif_pulse_timer.sv
// rtl/verif_pulse_timer.sv - enabled period counter with one-cycle tick on its last count
module verif_pulse_timer #(
    parameter int PERIOD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_o
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick_o    = en && w_at_last;

    // Count enabled cycles and wrap after the last one; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/verif_run_ctrl.sv
// rtl/verif_run_ctrl.sv - multi-loop test-run sequencer with error tracking, heartbeat and watchdog
module verif_run_ctrl #(
    parameter int NUM_CH            = 4,
    parameter int MAX_LOOP_COUNT    = verif_pkg::MAX_LOOP_COUNT,
    parameter int HEART_BEAT_EN     = verif_pkg::HEART_BEAT,
    parameter int HEART_BEAT_CYCLES = verif_pkg::HEART_BEAT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES    = verif_pkg::TIMEOUT_CYCLES_DEF,
    parameter int STOP_AT_ERROR     = verif_pkg::STOP_AT_ERROR,
    parameter int ERR_CNT_W         = 16,
    localparam int LOOP_W           = $clog2(MAX_LOOP_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [NUM_CH-1:0]    ch_done_i,
    input  logic [NUM_CH-1:0]    ch_err_i,
    output logic                 loop_start_o,
    output logic                 busy_o,
    output logic                 heartbeat_o,
    output logic [LOOP_W-1:0]    loop_cnt_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [NUM_CH-1:0]    err_ch_mask_o,
    output logic                 timeout_o,
    output logic                 pass_o,
    output logic                 fail_o
);

    import verif_pkg::*;

    localparam int SUM_W = ERR_CNT_W + 6;
    localparam logic [SUM_W-1:0]  ERR_MAX   = {6'd0, {ERR_CNT_W{1'b1}}};
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(MAX_LOOP_COUNT - 1);

    run_state_t           r_state;
    logic                 r_loop_start;
    logic                 r_busy;
    logic [LOOP_W-1:0]    r_loop_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [NUM_CH-1:0]    r_err_mask;
    logic [NUM_CH-1:0]    r_done_mask;
    logic                 r_timeout;
    logic                 r_pass;
    logic                 r_fail;

    logic                 w_start_ok;
    logic                 w_done_all;
    logic                 w_any_err;
    logic                 w_hb_tick;
    logic                 w_wd_tick;
    logic [5:0]           w_err_pop;
    logic [SUM_W-1:0]     w_err_sum;
    logic [ERR_CNT_W-1:0] w_err_next;

    assign w_start_ok = start_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_done_all = &(r_done_mask | ch_done_i);
    assign w_any_err  = |ch_err_i;

    // Error counter advances by the number of erroring channels, clamped at all-ones
    always_comb begin
        w_err_pop  = popcount(32'(ch_err_i));
        w_err_sum  = {6'd0, r_err_cnt} + {{ERR_CNT_W{1'b0}}, w_err_pop};
        w_err_next = (w_err_sum > ERR_MAX) ? {ERR_CNT_W{1'b1}} : w_err_sum[ERR_CNT_W-1:0];
    end

    // Heartbeat spans the whole run: restarted only when a new run is launched
    verif_pulse_timer #(
        .PERIOD (HEART_BEAT_CYCLES)
    ) u_heartbeat (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (r_busy),
        .clr    (w_start_ok),
        .tick_o (w_hb_tick)
    );

    // Watchdog counts RUN cycles of the current loop; its tick marks the last allowed cycle
    verif_pulse_timer #(
        .PERIOD (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (r_state == RUN),
        .clr    (r_state == LAUNCH),
        .tick_o (w_wd_tick)
    );

    // Run sequencer: state, loop/error bookkeeping and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_loop_start <= 1'b0;
            r_busy       <= 1'b0;
            r_loop_cnt   <= '0;
            r_err_cnt    <= '0;
            r_err_mask   <= '0;
            r_done_mask  <= '0;
            r_timeout    <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_loop_start <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state      <= LAUNCH;
                        r_loop_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_loop_cnt   <= '0;
                        r_err_cnt    <= '0;
                        r_err_mask   <= '0;
                        r_timeout    <= 1'b0;
                        r_pass       <= 1'b0;
                        r_fail       <= 1'b0;
                    end
                end
                LAUNCH: begin
                    r_done_mask <= '0;
                    r_state     <= RUN;
                end
                RUN: begin
                    r_done_mask <= r_done_mask | ch_done_i;
                    r_err_mask  <= r_err_mask | ch_err_i;
                    r_err_cnt   <= w_err_next;
                    if ((STOP_AT_ERROR != 0) && w_any_err) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b1;
                    end else if (w_done_all) begin
                        r_state <= CHECK;
                    end else if (w_wd_tick) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_fail    <= 1'b1;
                    end
                end
                CHECK: begin
                    r_loop_cnt <= r_loop_cnt + LOOP_W'(1);
                    if (r_loop_cnt == LOOP_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_pass  <= (r_err_cnt == '0);
                        r_fail  <= (r_err_cnt != '0);
                    end else begin
                        r_state      <= LAUNCH;
                        r_loop_start <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign loop_start_o  = r_loop_start;
    assign busy_o        = r_busy;
    assign heartbeat_o   = (HEART_BEAT_EN != 0) ? w_hb_tick : 1'b0;
    assign loop_cnt_o    = r_loop_cnt;
    assign err_cnt_o     = r_err_cnt;
    assign err_ch_mask_o = r_err_mask;
    assign timeout_o     = r_timeout;
    assign pass_o        = r_pass;
    assign fail_o        = r_fail;

endmodule

// File: tb/tb_verif_run_ctrl.sv
// tb/tb_verif_run_ctrl.sv - self-checking bench for verif_run_ctrl
module tb_verif_run_ctrl;

    localparam int HB    = 8;
    localparam int TMO   = 20;
    localparam int NLOOP = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: continue on error, 16-bit count; 1: stop at error; 2: 2-bit count
    logic       start_v [3];
    logic [3:0] done_v  [3];
    logic [3:0] err_v   [3];

    logic [2:0]  ls, busy, hb, to, pass, fail;
    logic [1:0]  lc_a, lc_b, lc_c;
    logic [3:0]  msk_a, msk_b, msk_c;
    logic [15:0] ec_a, ec_b;
    logic [1:0]  ec_c;

    int n_pass = 0;
    int n_tot  = 0;
    int n_ls   = 0;
    int n_hb   = 0;

    verif_run_ctrl #(.NUM_CH(4), .MAX_LOOP_COUNT(NLOOP), .HEART_BEAT_EN(1), .HEART_BEAT_CYCLES(HB),
                     .TIMEOUT_CYCLES(TMO), .STOP_AT_ERROR(0), .ERR_CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .ch_done_i(done_v[0]), .ch_err_i(err_v[0]),
        .loop_start_o(ls[0]), .busy_o(busy[0]), .heartbeat_o(hb[0]), .loop_cnt_o(lc_a),
        .err_cnt_o(ec_a), .err_ch_mask_o(msk_a), .timeout_o(to[0]), .pass_o(pass[0]), .fail_o(fail[0]));

    verif_run_ctrl #(.NUM_CH(4), .MAX_LOOP_COUNT(NLOOP), .HEART_BEAT_EN(1), .HEART_BEAT_CYCLES(HB),
                     .TIMEOUT_CYCLES(TMO), .STOP_AT_ERROR(1), .ERR_CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .ch_done_i(done_v[1]), .ch_err_i(err_v[1]),
        .loop_start_o(ls[1]), .busy_o(busy[1]), .heartbeat_o(hb[1]), .loop_cnt_o(lc_b),
        .err_cnt_o(ec_b), .err_ch_mask_o(msk_b), .timeout_o(to[1]), .pass_o(pass[1]), .fail_o(fail[1]));

    verif_run_ctrl #(.NUM_CH(4), .MAX_LOOP_COUNT(NLOOP), .HEART_BEAT_EN(1), .HEART_BEAT_CYCLES(HB),
                     .TIMEOUT_CYCLES(TMO), .STOP_AT_ERROR(0), .ERR_CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[2]), .ch_done_i(done_v[2]), .ch_err_i(err_v[2]),
        .loop_start_o(ls[2]), .busy_o(busy[2]), .heartbeat_o(hb[2]), .loop_cnt_o(lc_c),
        .err_cnt_o(ec_c), .err_ch_mask_o(msk_c), .timeout_o(to[2]), .pass_o(pass[2]), .fail_o(fail[2]));

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 launch, 2 run, 3 check, 4 done
    int     m_ph    [3];
    int     m_loop  [3];
    int     m_err   [3];
    int     m_runc  [3];
    int     m_busyc [3];
    bit [3:0] m_mask [3];
    bit [3:0] m_seen [3];
    bit     m_to    [3];
    bit     m_pass  [3];
    bit     m_fail  [3];

    function automatic int err_max(input int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_ph[k] = 0; m_loop[k] = 0; m_err[k] = 0; m_runc[k] = 0; m_busyc[k] = 0;
                m_mask[k] = 0; m_seen[k] = 0; m_to[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
            end else begin
                if (m_ph[k] >= 1 && m_ph[k] <= 3) m_busyc[k] = m_busyc[k] + 1;
                case (m_ph[k])
                    0, 4: if (start_v[k]) begin
                        m_loop[k] = 0; m_err[k] = 0; m_mask[k] = 0;
                        m_to[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
                        m_busyc[k] = 0; m_ph[k] = 1;
                    end
                    1: begin m_seen[k] = 0; m_runc[k] = 0; m_ph[k] = 2; end
                    2: begin
                        m_seen[k] = m_seen[k] | done_v[k];
                        m_mask[k] = m_mask[k] | err_v[k];
                        m_err[k]  = m_err[k] + $countones(err_v[k]);
                        if (m_err[k] > err_max(k)) m_err[k] = err_max(k);
                        m_runc[k] = m_runc[k] + 1;
                        if (k == 1 && err_v[k] != 0) m_ph[k] = 4;
                        else if (m_seen[k] == 4'hF) m_ph[k] = 3;
                        else if (m_runc[k] == TMO) begin m_to[k] = 1; m_ph[k] = 4; end
                        if (m_ph[k] == 4) begin
                            m_pass[k] = (m_err[k] == 0) && !m_to[k];
                            m_fail[k] = !m_pass[k];
                        end
                    end
                    3: begin
                        m_loop[k] = m_loop[k] + 1;
                        if (m_loop[k] == NLOOP) begin
                            m_ph[k] = 4;
                            m_pass[k] = (m_err[k] == 0);
                            m_fail[k] = !m_pass[k];
                        end else m_ph[k] = 1;
                    end
                    default: m_ph[k] = 0;
                endcase
            end
        end
    end

    function automatic logic [27:0] exp_vec(input int k);
        logic b;
        b = (m_ph[k] >= 1 && m_ph[k] <= 3);
        return {m_ph[k] == 1, b, b && (m_busyc[k] % HB == HB - 1), m_to[k], m_pass[k], m_fail[k],
                2'(m_loop[k]), m_mask[k], 16'(m_err[k])};
    endfunction

    function automatic logic [27:0] act_vec(input int k);
        case (k)
            0:       return {ls[0], busy[0], hb[0], to[0], pass[0], fail[0], lc_a, msk_a, ec_a};
            1:       return {ls[1], busy[1], hb[1], to[1], pass[1], fail[1], lc_b, msk_b, ec_b};
            default: return {ls[2], busy[2], hb[2], to[2], pass[2], fail[2], lc_c, msk_c, {14'd0, ec_c}};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    endtask

    // Every cycle, all outputs of every instance against the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) chk($sformatf("model_inst%0d", k), 32'(act_vec(k)), 32'(exp_vec(k)));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (ls[0]) n_ls++;
        if (hb[0]) n_hb++;
    endtask

    task automatic drv(input logic [2:0] sel, input logic st, input logic [3:0] dn, input logic [3:0] er);
        for (int k = 0; k < 3; k++) begin
            start_v[k] = sel[k] ? st : 1'b0;
            done_v[k]  = sel[k] ? dn : 4'd0;
            err_v[k]   = sel[k] ? er : 4'd0;
        end
    endtask

    task automatic start_run(input logic [2:0] sel);
        drv(sel, 1'b1, 4'd0, 4'd0);
        tick();
        drv(3'b000, 1'b0, 4'd0, 4'd0);
    endtask

    // From the LAUNCH cycle: one RUN cycle per channel done, then CHECK
    task automatic run_loop(input logic [2:0] sel, input logic [3:0] e0, input logic [3:0] e1);
        chk("loop_start_seen", 32'(ls & sel), 32'(sel));
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(sel, 1'b0, 4'(1 << i), (i == 0) ? e0 : ((i == 1) ? e1 : 4'd0));
            tick();
        end
        drv(3'b000, 1'b0, 4'd0, 4'd0);
        tick();
    endtask

    initial begin
        int n;
        drv(3'b000, 1'b0, 4'd0, 4'd0);
        repeat (3) tick();
        for (int k = 0; k < 3; k++) chk($sformatf("reset_state%0d", k), 32'(act_vec(k)), 32'd0);
        rst_n = 1'b1;
        tick();

        // clean run on instances 0 and 2
        n_ls = 0; n_hb = 0;
        start_run(3'b101);
        repeat (NLOOP) run_loop(3'b101, 4'd0, 4'd0);
        chk("clean_loop_cnt", 32'(lc_a), 32'd3);
        chk("clean_pass", 32'(pass[0]), 32'd1);
        chk("clean_fail", 32'(fail[0]), 32'd0);
        chk("clean_err_cnt", 32'(ec_a), 32'd0);
        chk("clean_busy", 32'(busy[0]), 32'd0);
        chk("clean_loop_starts", n_ls, 32'd3);
        chk("clean_heartbeats", n_hb, 32'd2);

        // multi-error run; restart from DONE clears counters
        start_run(3'b101);
        chk("restart_loop_start", 32'(ls[0]), 32'd1);
        chk("restart_loop_cnt", 32'(lc_a), 32'd0);
        chk("restart_pass", 32'(pass[0]), 32'd0);
        run_loop(3'b101, 4'd0, 4'd0);
        run_loop(3'b101, 4'b1010, 4'b0010);
        run_loop(3'b101, 4'd0, 4'd0);
        chk("multi_err_cnt", 32'(ec_a), 32'd3);
        chk("multi_err_mask", 32'(msk_a), 32'b1010);
        chk("multi_fail", 32'(fail[0]), 32'd1);
        chk("multi_pass", 32'(pass[0]), 32'd0);
        chk("multi_loop_cnt", 32'(lc_a), 32'd3);

        // saturation: five errors
        start_run(3'b101);
        run_loop(3'b101, 4'b1111, 4'b0001);
        repeat (2) run_loop(3'b101, 4'd0, 4'd0);
        chk("sat_wide_cnt", 32'(ec_a), 32'd5);
        chk("sat_narrow_cnt", 32'(ec_c), 32'd3);
        chk("sat_narrow_fail", 32'(fail[2]), 32'd1);

        // stop at first error on instance 1
        start_run(3'b010);
        tick();
        drv(3'b010, 1'b0, 4'b0001, 4'd0);
        tick();
        drv(3'b010, 1'b0, 4'd0, 4'b0100);
        tick();
        drv(3'b000, 1'b0, 4'd0, 4'd0);
        chk("stop_busy", 32'(busy[1]), 32'd0);
        chk("stop_loop_cnt", 32'(lc_b), 32'd0);
        chk("stop_fail", 32'(fail[1]), 32'd1);
        chk("stop_err_cnt", 32'(ec_b), 32'd1);
        chk("stop_err_mask", 32'(msk_b), 32'b0100);

        // timeout: channel 3 never completes; a start during RUN is ignored
        n_ls = 0;
        start_run(3'b001);
        tick();
        n = 0;
        while (busy[0] && n < 40) begin
            drv(3'b001, n == 4, (n < 3) ? 4'(1 << n) : 4'd0, 4'd0);
            tick();
            n++;
        end
        drv(3'b000, 1'b0, 4'd0, 4'd0);
        chk("timeout_run_cycles", n, 32'd20);
        chk("timeout_flag", 32'(to[0]), 32'd1);
        chk("timeout_fail", 32'(fail[0]), 32'd1);
        chk("timeout_loop_starts", n_ls, 32'd1);

        // last done on the watchdog's final cycle wins
        start_run(3'b001);
        tick();
        for (int i = 0; i < TMO; i++) begin
            drv(3'b001, 1'b0, (i < 3) ? 4'(1 << i) : ((i == TMO - 1) ? 4'b1000 : 4'd0), 4'd0);
            tick();
        end
        drv(3'b000, 1'b0, 4'd0, 4'd0);
        chk("expiry_done_busy", 32'(busy[0]), 32'd1);
        chk("expiry_done_timeout", 32'(to[0]), 32'd0);
        tick();
        repeat (2) run_loop(3'b001, 4'd0, 4'd0);
        chk("expiry_run_pass", 32'(pass[0]), 32'd1);
        chk("expiry_run_loops", 32'(lc_a), 32'd3);

        // asynchronous reset in the middle of RUN
        start_run(3'b001);
        tick();
        drv(3'b001, 1'b0, 4'b0011, 4'b0001);
        tick();
        drv(3'b000, 1'b0, 4'd0, 4'd0);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_run", 32'(act_vec(0)), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

endmodule
